result_drain: RTL and testbench
===============================

RESULT_DRAIN -- requirements
Module: result_drain

Interface
REQ-001 The block SHALL have parameter DWIDTH, default 8, bits per matrix element.
REQ-002 The block SHALL have parameter MAT_SIZE, default 4, elements per row and rows per tile.
REQ-003 The block SHALL have parameter AWIDTH, default 10, byte-address width of the C RAM.
REQ-004 The block SHALL have parameter STRIDE_W, default 8, width of the row stride.
REQ-005 Reset SHALL be resetn, synchronous, active-low; clock SHALL be clk.
REQ-006 Ports SHALL be, as name / direction / width / meaning:
- clk, in, 1, clock.
- resetn, in, 1, synchronous active-low reset.
- start, in, 1, begin draining one tile; sampled in IDLE only.
- clear_done, in, 1, release DONE.
- base_addr, in, AWIDTH, byte address of row 0.
- stride, in, STRIDE_W, byte distance between rows.
- row_mask, in, MAT_SIZE, bit r=1 means row r is drained.
- ram_addr, out, AWIDTH, C RAM read address.
- ram_rdata, in, MAT_SIZE*DWIDTH, C RAM read data; valid 1 cycle after ram_addr.
- out_data, out, MAT_SIZE*DWIDTH, streamed row.
- out_valid, out, 1, out_data valid.
- out_ready, in, 1, downstream accepts the beat.
- out_last, out, 1, final beat of the tile.
- busy, out, 1, high outside IDLE and DONE.
- done, out, 1, high in DONE.
- stall_count, out, 16, backpressure cycle count.

Function
REQ-007 The state machine SHALL have states IDLE, READ, FLUSH and DONE.
REQ-008 Transitions SHALL be:
- IDLE->READ on start when row_mask != 0.
- IDLE->DONE on start when row_mask == 0, with no beats emitted.
- READ->FLUSH after the last enabled row's read is issued.
- FLUSH->DONE when the FIFO is empty and no read is in flight.
- DONE->IDLE on clear_done.
REQ-009 On start, base_addr, stride and row_mask SHALL be latched; later changes SHALL have no effect on the tile in progress.
REQ-010 Row r SHALL be read at address (base_addr + r*stride) mod 2^AWIDTH, wrapping silently.
REQ-011 Rows SHALL be visited in ascending order; masked-off rows SHALL be skipped with no idle cycle.
REQ-012 A read SHALL issue in a cycle only if (FIFO occupancy + reads in flight) < 2.
REQ-013 ram_rdata SHALL be written into the FIFO exactly 1 cycle after its read is issued.
REQ-014 Rows SHALL be buffered in a 2-entry FIFO; out_valid SHALL be high when the FIFO is not empty, and out_data SHALL be the FIFO head.
REQ-015 A beat SHALL transfer when out_valid and out_ready are both high.
REQ-016 out_data and out_last SHALL stay stable while out_valid is high and out_ready is low.
REQ-017 out_last SHALL be high only on the beat carrying the highest-index enabled row.
REQ-018 With out_ready held high, throughput SHALL be one beat per cycle.
REQ-019 The first beat SHALL appear 2 cycles after the start cycle.
REQ-020 A simultaneous FIFO push and pop SHALL keep occupancy unchanged.
REQ-021 start SHALL be ignored in READ, FLUSH and DONE.
REQ-022 clear_done SHALL be ignored outside DONE.
REQ-023 done SHALL stay high until clear_done.
REQ-024 ram_addr SHALL hold its last value when no read is issued.

Reset
REQ-025 On resetn low at a clk edge, the block SHALL enter IDLE and flush the FIFO and in-flight tracking.
REQ-026 On reset, out_valid, out_last, busy and done SHALL be 0.
REQ-027 On reset, ram_addr, out_data and stall_count SHALL be 0.
REQ-028 Reset mid-tile SHALL abandon the tile; the response to an outstanding read SHALL be discarded.

Configuration
REQ-029 With RESULT_DRAIN_STALL_CNT_EN defined, stall_count SHALL increment in each cycle with out_valid=1 and out_ready=0.
REQ-030 With RESULT_DRAIN_STALL_CNT_EN defined, stall_count SHALL saturate at 16'hFFFF and clear to 0 on an accepted start.
REQ-031 Without RESULT_DRAIN_STALL_CNT_EN, stall_count SHALL be tied to 0 and no counter logic SHALL be synthesized.

Structure
REQ-032 Package result_drain_pkg SHALL hold the state enumeration, STALL_CNT_W=16 and FIFO_DEPTH=2.
REQ-033 The FIFO SHALL be sub-module drain_fifo2: 2 entries, width MAT_SIZE*DWIDTH+1 (data plus last), synchronous, with full, empty and count outputs.

Verification
REQ-034 Basic tile: base=0x040, stride=4, mask=4'b1111, out_ready=1 -> ram_addr 0x040, 0x044, 0x048, 0x04C; 4 consecutive beats; out_last on beat 4; done 1 cycle after flush completes.
REQ-035 Mask skip: mask=4'b1010, base=0x100, stride=0x10 -> reads at 0x110 and 0x130 only; 2 beats; out_last on the 0x130 row.
REQ-036 Backpressure: out_ready low for 5 cycles after the first beat becomes valid -> no more than 2 reads outstanding or buffered; out_data stable; data order preserved; stall_count=5 with the macro, 0 without.
REQ-037 Wrap and empty mask: AWIDTH=10, base=0x3FC, stride=4 -> second read at 0x000; mask=0 -> done on the cycle after start, out_valid never high.
REQ-038 Reset mid-tile: resetn low while a read is in flight -> next cycle out_valid=0, busy=0, FIFO empty; a new start then drains correctly.
REQ-039 Control hygiene: start asserted during READ, and clear_done asserted in IDLE -> no state change.

Source files
------------

// File: rtl/result_drain_pkg.sv
// Shared types and constants for the result drain block.
package result_drain_pkg;

  localparam int STALL_CNT_W = 16;
  localparam int FIFO_DEPTH  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/drain_fifo2.sv
// Two-entry synchronous FIFO carrying one row plus its last-beat flag.
module drain_fifo2
  import result_drain_pkg::*;
#(
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] mem0_q, mem1_q;
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == 2'd0);
  assign full_o  = (count_q == 2'(FIFO_DEPTH));
  assign count_o = count_q;
  assign head_o  = rd_ptr_q ? mem1_q : mem0_q;

  // A push into a full FIFO is only taken when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      mem0_q   <= '0;
      mem1_q   <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        if (wr_ptr_q) mem1_q <= push_data_i;
        else          mem0_q <= push_data_i;
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/result_drain.sv
// Streams the enabled rows of one C-RAM tile out through a 2-entry FIFO.
// Defining RESULT_DRAIN_STALL_CNT_EN builds the backpressure stall counter.
module result_drain
  import result_drain_pkg::*;
#(
  parameter int DWIDTH   = 8,
  parameter int MAT_SIZE = 4,
  parameter int AWIDTH   = 10,
  parameter int STRIDE_W = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       start,
  input  logic                       clear_done,
  input  logic [AWIDTH-1:0]          base_addr,
  input  logic [STRIDE_W-1:0]        stride,
  input  logic [MAT_SIZE-1:0]        row_mask,
  output logic [AWIDTH-1:0]          ram_addr,
  input  logic [MAT_SIZE*DWIDTH-1:0] ram_rdata,
  output logic [MAT_SIZE*DWIDTH-1:0] out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done,
  output logic [STALL_CNT_W-1:0]     stall_count,
  output logic [1:0]                 dbg_state
);

  localparam int ROW_W = MAT_SIZE * DWIDTH;
  localparam int IDX_W = (MAT_SIZE > 1) ? $clog2(MAT_SIZE) : 1;

  state_e                state_q, state_d;
  logic [AWIDTH-1:0]     base_q, base_d;
  logic [STRIDE_W-1:0]   stride_q, stride_d;
  logic [MAT_SIZE-1:0]   rem_q, rem_d;
  logic [AWIDTH-1:0]     addr_q;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;

  logic                  issue;
  logic [MAT_SIZE-1:0]   issue_mask, issue_rest;
  logic [IDX_W-1:0]      issue_idx;
  logic [AWIDTH-1:0]     issue_base;
  logic [STRIDE_W-1:0]   issue_stride;
  logic                  credit_ok;
  logic                  pop;

  logic [ROW_W:0]        fifo_head;
  logic                  fifo_full, fifo_empty;
  logic [1:0]            fifo_count;

  function automatic logic [IDX_W-1:0] lowest_row(input logic [MAT_SIZE-1:0] m);
    lowest_row = '0;
    for (int r = MAT_SIZE - 1; r >= 0; r--) begin
      if (m[r]) lowest_row = IDX_W'(r);
    end
  endfunction

  function automatic logic [AWIDTH-1:0] row_addr(input logic [AWIDTH-1:0]   b,
                                                 input logic [STRIDE_W-1:0] s,
                                                 input logic [IDX_W-1:0]    idx);
    return b + AWIDTH'(idx) * AWIDTH'(s);
  endfunction

  // Output handshake: a beat moves on a cycle where out_valid and out_ready are
  // both high; while out_valid is high and out_ready low, out_data/out_last hold.
  assign out_valid = ~fifo_empty;
  assign out_data  = fifo_head[ROW_W-1:0];
  assign out_last  = out_valid & fifo_head[ROW_W];
  assign pop       = out_valid & out_ready;

  // Slot budget (FIFO entries + read in flight) is two, counting a same-cycle pop
  // as already freed so a steady stream sustains one beat per cycle.
  assign credit_ok = pop | (~fifo_full & ~((fifo_count == 2'd1) & inflight_q));

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    stride_d     = stride_q;
    rem_d        = rem_q;
    issue        = 1'b0;
    issue_mask   = rem_q;
    issue_base   = base_q;
    issue_stride = stride_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          base_d   = base_addr;
          stride_d = stride;
          if (row_mask == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d      = ST_READ;
            issue        = 1'b1;
            issue_mask   = row_mask;
            issue_base   = base_addr;
            issue_stride = stride;
          end
        end
      end
      ST_READ: begin
        if (rem_q == '0) state_d = ST_FLUSH;
        else if (credit_ok) issue = 1'b1;
      end
      ST_FLUSH: begin
        if (fifo_empty && !inflight_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (clear_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    issue_idx  = lowest_row(issue_mask);
    issue_rest = issue_mask & ~(MAT_SIZE'(1) << issue_idx);
    if (issue) begin
      rem_d = issue_rest;
      if (state_q == ST_READ && issue_rest == '0) state_d = ST_FLUSH;
    end

    inflight_d      = issue;
    inflight_last_d = issue & (issue_rest == '0);
  end

  assign ram_addr = issue ? row_addr(issue_base, issue_stride, issue_idx) : addr_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q         <= ST_IDLE;
      base_q          <= '0;
      stride_q        <= '0;
      rem_q           <= '0;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      base_q          <= base_d;
      stride_q        <= stride_d;
      rem_q           <= rem_d;
      addr_q          <= ram_addr;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  drain_fifo2 #(
    .WIDTH(ROW_W + 1)
  ) u_fifo (
    .clk         (clk),
    .resetn      (resetn),
    .push_i      (inflight_q),
    .push_data_i ({inflight_last_q, ram_rdata}),
    .pop_i       (pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign busy      = (state_q == ST_READ) || (state_q == ST_FLUSH);
  assign done      = (state_q == ST_DONE);
  assign dbg_state = state_q;

`ifdef RESULT_DRAIN_STALL_CNT_EN
  logic [STALL_CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == ST_IDLE && start) stall_d = '0;
    else if (out_valid && !out_ready && stall_q != '1) stall_d = stall_q + STALL_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!resetn) stall_q <= '0;
    else         stall_q <= stall_d;
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain: vector table, hand sequences, random tiles.
module tb_result_drain;

  localparam int DWIDTH   = 8;
  localparam int MAT_SIZE = 4;
  localparam int AWIDTH   = 10;
  localparam int STRIDE_W = 8;
  localparam int ROW_W    = MAT_SIZE * DWIDTH;

  logic                clk;
  logic                resetn;
  logic                start;
  logic                clear_done;
  logic [AWIDTH-1:0]   base_addr;
  logic [STRIDE_W-1:0] stride;
  logic [MAT_SIZE-1:0] row_mask;
  logic [AWIDTH-1:0]   ram_addr;
  logic [ROW_W-1:0]    ram_rdata;
  logic [ROW_W-1:0]    out_data;
  logic                out_valid;
  logic                out_ready;
  logic                out_last;
  logic                busy;
  logic                done;
  logic [15:0]         stall_count;
  logic [1:0]          dbg_state;

  result_drain #(
    .DWIDTH(DWIDTH), .MAT_SIZE(MAT_SIZE), .AWIDTH(AWIDTH), .STRIDE_W(STRIDE_W)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .clear_done(clear_done),
    .base_addr(base_addr), .stride(stride), .row_mask(row_mask),
    .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done), .stall_count(stall_count), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- C RAM model: data valid one cycle after address ----------------
  function automatic logic [ROW_W-1:0] mem_word(input logic [AWIDTH-1:0] a);
    return (ROW_W'(a) * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  always @(posedge clk) ram_rdata <= mem_word(ram_addr);

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [ROW_W:0] exp_q[$];
  int beats = 0;
  int stall_model = 0;
  logic [AWIDTH-1:0] prev_addr = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: enabled rows in ascending order, address wraps at 2^AWIDTH.
  task automatic build_expect(input logic [AWIDTH-1:0] b, input logic [STRIDE_W-1:0] s,
                              input logic [MAT_SIZE-1:0] m);
    int top;
    int unsigned a;
    top = -1;
    for (int r = 0; r < MAT_SIZE; r++) if (m[r]) top = r;
    for (int r = 0; r < MAT_SIZE; r++) begin
      if (m[r]) begin
        a = (int'(b) + r * int'(s)) % (1 << AWIDTH);
        exp_q.push_back({(r == top), mem_word(AWIDTH'(a))});
      end
    end
  endtask

  // Monitor samples on the falling edge, away from the active edge.
  logic [ROW_W-1:0] held_data;
  logic             held_last;
  logic             held_valid = 1'b0;
  logic [ROW_W:0]   exp_beat;

  always @(negedge clk) begin
    if (!resetn) begin
      held_valid = 1'b0;
    end else begin
      if (held_valid) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_data", out_data, held_data);
        check("hold_last", out_last, held_last);
      end
      if (out_valid) begin
        if (out_ready) begin
          beats++;
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 1'b1, 1'b0);
          end else begin
            exp_beat = exp_q.pop_front();
            check("beat_data_last", {out_last, out_data}, exp_beat);
          end
        end else begin
          stall_model++;
        end
      end
      held_valid = out_valid && !out_ready;
      held_data  = out_data;
      held_last  = out_last;
    end
  end

  // ---------------- driver ----------------
  typedef struct {
    logic [AWIDTH-1:0]   base;
    logic [STRIDE_W-1:0] stride;
    logic [MAT_SIZE-1:0] mask;
    int                  stall;
    int                  exp_beats;
    logic [AWIDTH-1:0]   exp_last;
    logic [15:0]         exp_stall;
  } vec_t;

  vec_t tbl[8];

  // Entered and left at #1 after a rising edge.
  task automatic run_tile(input vec_t v, input bit rnd, input bit hold);
    int cyc, first, lastv, nvalid, stall_left;
    logic [15:0] want_stall;
    exp_q.delete();
    build_expect(v.base, v.stride, v.mask);
    base_addr = v.base; stride = v.stride; row_mask = v.mask;
    start = 1'b1; out_ready = 1'b1;
    stall_model = 0; beats = 0;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    base_addr = AWIDTH'($urandom); stride = STRIDE_W'($urandom); row_mask = MAT_SIZE'($urandom);
    cyc = 0; first = -1; lastv = -1; nvalid = 0; stall_left = 0;
    while (cyc < 300) begin
      if (out_valid) begin
        if (first < 0) begin first = cyc; stall_left = v.stall; end
        lastv = cyc; nvalid++;
      end
      if (done) break;
      if (rnd) out_ready = ($urandom_range(0, 3) != 0);
      else if (stall_left > 0) begin out_ready = 1'b0; stall_left--; end
      else out_ready = 1'b1;
      @(posedge clk); #1; cyc++;
    end
    check("done_reached", done, 1'b1);
    check("beat_count", beats, v.exp_beats);
    check("queue_drained", exp_q.size(), 0);
    check("ram_addr_hold", ram_addr, v.exp_last);
    check("busy_in_done", busy, 1'b0);
    if (!rnd) begin
      if (v.mask == '0) begin
        check("empty_mask_done_cyc", cyc, 0);
        check("empty_mask_no_valid", nvalid, 0);
      end else begin
        check("first_beat_latency", first, 1);
        if (v.stall == 0) begin
          check("beats_back_to_back", lastv - first + 1, v.exp_beats);
          check("done_after_flush", cyc - lastv, 2);
        end
      end
    end
`ifdef RESULT_DRAIN_STALL_CNT_EN
    want_stall = rnd ? 16'(stall_model) : v.exp_stall;
`else
    want_stall = 16'd0;
`endif
    check("stall_count", stall_count, want_stall);
    if (hold) begin
      @(posedge clk); #1;
      check("start_ignored_in_done", done, 1'b1);
      start = 1'b0;
    end
    clear_done = 1'b1;
    @(posedge clk); #1;
    clear_done = 1'b0;
    check("clear_done_release", done, 1'b0);
    check("idle_not_busy", busy, 1'b0);
    prev_addr = v.exp_last;
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t rv;
    int   top;
    resetn = 1'b0; start = 1'b0; clear_done = 1'b0; out_ready = 1'b0;
    base_addr = '0; stride = '0; row_mask = '0;

    tbl[0] = '{10'h040, 8'h04, 4'b1111, 0, 4, 10'h04C, 16'd0};
    tbl[1] = '{10'h100, 8'h10, 4'b1010, 0, 2, 10'h130, 16'd0};
    tbl[2] = '{10'h200, 8'h08, 4'b1111, 5, 4, 10'h218, 16'd5};
    tbl[3] = '{10'h3FC, 8'h04, 4'b0011, 0, 2, 10'h000, 16'd0};
    tbl[4] = '{10'h123, 8'h01, 4'b0000, 0, 0, 10'h000, 16'd0};
    tbl[5] = '{10'h3F0, 8'hFF, 4'b1001, 0, 2, 10'h2ED, 16'd0};
    tbl[6] = '{10'h000, 8'h00, 4'b0100, 0, 1, 10'h000, 16'd0};
    tbl[7] = '{10'h155, 8'h33, 4'b1000, 2, 1, 10'h1EE, 16'd2};

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ram_addr", ram_addr, '0);
    check("rst_out_data", out_data, '0);
    check("rst_stall_count", stall_count, '0);
    check("rst_state_idle", dbg_state, 2'd0);
    resetn = 1'b1;
    @(posedge clk); #1;

    // clear_done outside DONE has no effect
    clear_done = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    clear_done = 1'b0;
    check("clear_in_idle_done", done, 1'b0);
    check("clear_in_idle_busy", busy, 1'b0);
    check("clear_in_idle_state", dbg_state, 2'd0);

    for (int i = 0; i < 8; i++) run_tile(tbl[i], 1'b0, 1'b0);

    // start held high through READ/FLUSH/DONE
    run_tile(tbl[0], 1'b0, 1'b1);

    // reset while the first read is in flight
    exp_q.delete();
    base_addr = 10'h200; stride = 8'h08; row_mask = 4'b1111; start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("midtile_busy", busy, 1'b1);
    resetn = 1'b0;
    @(posedge clk); #1;
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_done", done, 1'b0);
    check("midrst_ram_addr", ram_addr, '0);
    resetn = 1'b1;
    @(posedge clk); #1;
    check("midrst_response_dropped", out_valid, 1'b0);
    prev_addr = '0;
    run_tile(tbl[1], 1'b0, 1'b0);

    // random tiles with random backpressure
    for (int n = 0; n < 25; n++) begin
      rv.base   = AWIDTH'($urandom);
      rv.stride = STRIDE_W'($urandom);
      rv.mask   = MAT_SIZE'($urandom_range(0, 15));
      rv.stall  = 0;
      rv.exp_beats = $countones(rv.mask);
      top = -1;
      for (int r = 0; r < MAT_SIZE; r++) if (rv.mask[r]) top = r;
      if (top < 0) rv.exp_last = prev_addr;
      else rv.exp_last = AWIDTH'((int'(rv.base) + top * int'(rv.stride)) % (1 << AWIDTH));
      rv.exp_stall = 16'd0;
      run_tile(rv, 1'b1, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
